// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: FSM state encoding,
// word/counter widths and the access legality check.
package mem_pkg;

  localparam int WORD_W  = 32;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  // An access is illegal when it is not word aligned or its word index
  // falls beyond the end of the array.
  function automatic logic addr_err(input logic [31:0] addr, input int depth);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(depth));
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with write enable and registered read.
// Contents and the read register are deliberately left unreset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     i_en,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WORD_W-1:0]        i_wdata,
  output logic [WORD_W-1:0]        o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request in IDLE, waits LATENCY
// cycles, performs the array access on RESP entry and pulses rsp_valid once.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);

  mem_state_e        r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_wr;
  logic [31:0]       r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_rsp_err;
  logic              r_rd_ok;

  logic              w_capture;
  logic              w_enter_resp;
  logic              w_acc_wr;
  logic [31:0]       w_acc_addr;
  logic [WORD_W-1:0] w_acc_wdata;
  logic              w_err;
  logic              w_ram_en;
  logic [WORD_W-1:0] w_ram_rdata;

  // With LATENCY=1 the access happens on the accepting edge itself, so the
  // live request is used in IDLE and the captured copy everywhere else.
  assign w_acc_wr    = (r_state == MEM_IDLE) ? req_wr    : r_wr;
  assign w_acc_addr  = (r_state == MEM_IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == MEM_IDLE) ? req_wdata : r_wdata;
  assign w_err       = addr_err(w_acc_addr, DEPTH);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (req_valid) begin
          w_capture = 1'b1;
          if (LATENCY == 1) begin
            w_state_next = MEM_RESP;
            w_cnt_next   = '0;
            w_enter_resp = 1'b1;
          end else begin
            w_state_next = MEM_BUSY;
            w_cnt_next   = CNT_W'(LATENCY - 1);
          end
        end
      end
      MEM_BUSY: begin
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt <= 1) begin
          w_state_next = MEM_RESP;
          w_cnt_next   = '0;
          w_enter_resp = 1'b1;
        end
      end
      MEM_RESP: begin
        w_state_next = MEM_IDLE;
      end
      default: begin
        w_state_next = MEM_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Blocks a write slipping through while reset is held with LATENCY=1.
  assign w_ram_en = w_enter_resp && !w_err && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= MEM_IDLE;
      r_cnt     <= '0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rsp_err <= 1'b0;
      r_rd_ok   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_capture) begin
        r_wr    <= req_wr;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_enter_resp) begin
        r_rsp_err <= w_err;
        r_rd_ok   <= !w_err && !w_acc_wr;
      end
    end
  end

  mem_array #(
    .DEPTH(DEPTH)
  ) u_mem_array (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_acc_wr),
    .i_addr  (w_acc_addr[2 +: AW]),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_ram_rdata)
  );

  // The RAM read register only changes on read responses, so gating it
  // gives zero for write/error responses and holds the last read value.
  assign req_ready = (r_state == MEM_IDLE);
  assign rsp_valid = (r_state == MEM_RESP);
  assign rsp_rdata = r_rd_ok ? w_ram_rdata : '0;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three builds (LATENCY 2, 1, 15) sharing one clock,
// directed table, reset-abort sequence and random traffic against a model.
module tb_mem_responder;

  localparam int NDUT  = 3;
  localparam int DEPTH = 256;
  localparam int LATS [NDUT] = '{2, 1, 15};

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [NDUT];
  logic        req_wr    [NDUT];
  logic [31:0] req_addr  [NDUT];
  logic [31:0] req_wdata [NDUT];
  logic        req_ready [NDUT];
  logic        rsp_valid [NDUT];
  logic [31:0] rsp_rdata [NDUT];
  logic        rsp_err   [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  bit [31:0] mdl [int];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    mem_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (LATS[gi])
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[gi]),
      .req_wr    (req_wr[gi]),
      .req_addr  (req_addr[gi]),
      .req_wdata (req_wdata[gi]),
      .req_ready (req_ready[gi]),
      .rsp_valid (rsp_valid[gi]),
      .rsp_rdata (rsp_rdata[gi]),
      .rsp_err   (rsp_err[gi])
    );
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Spec-level rules: legal iff word aligned and word index below DEPTH.
  function automatic bit model_err(input logic [31:0] addr);
    return (addr % 4 != 0) || ((addr / 4) >= DEPTH);
  endfunction

  function automatic int mkey(input int d, input logic [31:0] addr);
    return d * 65536 + int'(addr / 4);
  endfunction

  // One full transaction: present the request, hold req_valid until
  // req_ready returns, and check timing, pulse count and response fields.
  task automatic do_req(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rd, input bit chk_rd);
    int          lat    = LATS[d];
    int          n_rsp  = -1;
    int          n_rdy  = -1;
    int          pulses = 0;
    logic [31:0] got_rd = '0;
    logic        got_err = 1'b0;
    @(negedge clk);
    chk($sformatf("d%0d ready_before", d), 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_wr[d]    = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    for (int n = 1; n <= LATS[2] + 5; n++) begin
      @(negedge clk);
      if (rsp_valid[d]) begin
        pulses++;
        if (n_rsp < 0) begin
          n_rsp   = n;
          got_rd  = rsp_rdata[d];
          got_err = rsp_err[d];
        end
      end
      if (req_ready[d]) begin
        n_rdy = n;
        req_valid[d] = 1'b0;
        break;
      end
    end
    req_valid[d] = 1'b0;
    chk($sformatf("d%0d latency", d), 32'(n_rsp), 32'(lat));
    chk($sformatf("d%0d ready_return", d), 32'(n_rdy), 32'(lat + 1));
    chk($sformatf("d%0d pulses", d), 32'(pulses), 32'd1);
    chk($sformatf("d%0d err a=%h", d, addr), 32'(got_err), 32'(exp_err));
    if (chk_rd) begin
      chk($sformatf("d%0d rdata a=%h", d, addr), got_rd, exp_rd);
      chk($sformatf("d%0d rdata_hold a=%h", d, addr), rsp_rdata[d], exp_rd);
    end
    $display("txn d%0d %s addr=%h wdata=%h -> err=%0d rdata=%h (lat %0d)",
             d, wr ? "WR" : "RD", addr, wdata, got_err, got_rd, n_rsp);
  endtask

  // Random op checked against the associative-array model.
  task automatic run_op(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bit          e   = model_err(addr);
    bit          crd = 1'b1;
    logic [31:0] exp = '0;
    if (!e && !wr) begin
      if (mdl.exists(mkey(d, addr))) exp = mdl[mkey(d, addr)];
      else crd = 1'b0;
    end
    do_req(d, wr, addr, wdata, e, exp, crd);
    if (!e && wr) mdl[mkey(d, addr)] = wdata;
  endtask

  initial begin
    vec_t vecs [17];
    int   rv_pulses;
    for (int d = 0; d < NDUT; d++) begin
      req_valid[d] = 1'b0;
      req_wr[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
    end

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'hCAFE_0000, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hCAFE_0000};
    vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 32'h0000_0014, 32'h0000_0005, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0014, 32'h0,         1'b0, 32'h0000_0005};
    vecs[10] = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hA5A5_A5A5};
    vecs[12] = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0};
    vecs[13] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 1'b1, 32'h0};
    vecs[14] = '{1'b1, 32'h0000_0022, 32'h0000_0077, 1'b1, 32'h0};
    vecs[15] = '{1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h1111_1111};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d reset ready", d), 32'(req_ready[d]), 32'd1);
      chk($sformatf("d%0d reset rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("d%0d reset rdata", d), rsp_rdata[d], 32'h0);
      chk($sformatf("d%0d reset err", d), 32'(rsp_err[d]), 32'd0);
    end

    foreach (vecs[i]) begin
      do_req(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_err, vecs[i].exp_rd, 1'b1);
      if (vecs[i].wr && !vecs[i].exp_err) mdl[mkey(0, vecs[i].addr)] = vecs[i].wdata;
    end

    // Abort a pending write with an asynchronous reset pulse in BUSY.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_wr[0]    = 1'b1;
    req_addr[0]  = 32'h0000_0020;
    req_wdata[0] = 32'h1234_5678;
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("rst_abort busy_ready", 32'(req_ready[0]), 32'd0);
    #2 reset = 1'b1;
    #1 chk("rst_abort async_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    rv_pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid[0]) rv_pulses++;
    end
    chk("rst_abort no_rsp", 32'(rv_pulses), 32'd0);
    $display("txn d0 reset-abort of WR 00000020 <- 12345678, responses seen %0d", rv_pulses);
    do_req(0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h1111_1111, 1'b1);

    for (int d = 0; d < NDUT; d++) begin
      for (int k = 0; k < 40; k++) begin
        logic [31:0] a;
        int          w;
        w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH - 4, DEPTH + 3))
                                        : int'($urandom_range(0, 15));
        a = 32'(w) * 4;
        if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
        run_op(d, 1'($urandom_range(0, 1)), a, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
